// File: rtl/snn_pkg.sv
// Shared types and constants for the pixel sequencer and its spike counters.
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_RESULT
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_0    = 2'd1;
  localparam logic [1:0] CLS_1    = 2'd2;

  localparam rgb_t BLUE   = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
  localparam rgb_t YELLOW = '{r: 8'd255, g: 8'd255, b: 8'd0};
  localparam rgb_t BLACK  = '{r: 8'd0,   g: 8'd0,   b: 8'd0};

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating spike counter; exposes its next value so a decision can include
// the spike arriving on the same edge.
module snn_spike_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_d_o = count_d;

endmodule

// File: rtl/snn_pixel_sequencer.sv
// Per-pixel scheduler for the rate-coded SNN: accept pixel, reset layers,
// run the spike window, drain, then hand back a class/colour result.
module snn_pixel_sequencer
  import snn_pkg::*;
#(
  parameter int unsigned SP_STEPS         = 64,
  parameter int unsigned LAYER_DELAY      = 5,
  parameter int unsigned N_SP_TO_ACTIVATE = 25,
  parameter int unsigned CNT_W            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] r_st,
  output logic [7:0] g_st,
  output logic [7:0] b_st,
  output logic       res_ly_1,
  output logic       res_ly_2,
  input  logic       out_0,
  input  logic       out_1,
  output logic       cls_valid,
  input  logic       cls_ready,
  output logic [1:0] cls,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       busy
);

  localparam int unsigned STEP_W  = $clog2(SP_STEPS);
  localparam int unsigned DRAIN_W = $clog2(LAYER_DELAY + 1);

  state_e             state_q;
  logic [STEP_W-1:0]  step_q;
  logic [DRAIN_W-1:0] drain_q;
  rgb_t               st_q;
  rgb_t               rgb_q;
  logic [1:0]         cls_q;
  logic               cls_valid_q;
  logic               res_ly_q;
  logic               busy_q;

  logic               cnt_clr;
  logic               cnt_win;
  logic [CNT_W-1:0]   cnt0_d;
  logic [CNT_W-1:0]   cnt1_d;
  logic [1:0]         cls_d;
  rgb_t               rgb_d;

  assign pix_ready = (state_q == ST_IDLE) && !reset && !flush;

  // Spikes only count while the window (RUN + DRAIN) is open.
  assign cnt_clr = (state_q == ST_LOAD) || flush;
  assign cnt_win = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  snn_spike_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_win && out_0),
    .count_d_o(cnt0_d)
  );

  snn_spike_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clk_i    (clk),
    .reset_i  (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_win && out_1),
    .count_d_o(cnt1_d)
  );

  // Class decision; output neuron 0 wins a tie.
  always_comb begin
    cls_d = CLS_NONE;
    rgb_d = BLACK;
    if (cnt0_d >= CNT_W'(N_SP_TO_ACTIVATE)) begin
      cls_d = CLS_0;
      rgb_d = BLUE;
    end else if (cnt1_d >= CNT_W'(N_SP_TO_ACTIVATE)) begin
      cls_d = CLS_1;
      rgb_d = YELLOW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      drain_q     <= '0;
      st_q        <= BLACK;
      rgb_q       <= BLACK;
      cls_q       <= CLS_NONE;
      cls_valid_q <= 1'b0;
      res_ly_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      drain_q     <= '0;
      st_q        <= BLACK;
      cls_valid_q <= 1'b0;
      res_ly_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      res_ly_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pix_valid && pix_ready) begin
            st_q     <= '{r: r_in, g: g_in, b: b_in};
            res_ly_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          step_q  <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (step_q == STEP_W'(SP_STEPS - 1)) begin
            st_q    <= BLACK;
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_W'(LAYER_DELAY - 1)) begin
            cls_q       <= cls_d;
            rgb_q       <= rgb_d;
            cls_valid_q <= 1'b1;
            state_q     <= ST_RESULT;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end
        ST_RESULT: begin
          if (cls_ready) begin
            cls_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign r_st      = st_q.r;
  assign g_st      = st_q.g;
  assign b_st      = st_q.b;
  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;
  assign cls       = cls_q;
  assign cls_valid = cls_valid_q;
  assign res_ly_1  = res_ly_q;
  assign res_ly_2  = res_ly_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_snn_pixel_sequencer.sv
// Directed bench for snn_pixel_sequencer: reset, classification, tie priority,
// back-pressure, flush abort and back-to-back throughput.
module tb_snn_pixel_sequencer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] r_in, g_in, b_in;
  logic [7:0] r_st, g_st, b_st;
  logic       res_ly_1, res_ly_2;
  logic       out_0, out_1;
  logic       cls_valid;
  logic       cls_ready;
  logic [1:0] cls;
  logic [7:0] r_out, g_out, b_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int w_rise, w_bad, w_st_run, w_st_drain;
  int acc_a, acc_b, unstable;

  snn_pixel_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .r_in     (r_in),
    .g_in     (g_in),
    .b_in     (b_in),
    .r_st     (r_st),
    .g_st     (g_st),
    .b_st     (b_st),
    .res_ly_1 (res_ly_1),
    .res_ly_2 (res_ly_2),
    .out_0    (out_0),
    .out_1    (out_1),
    .cls_valid(cls_valid),
    .cls_ready(cls_ready),
    .cls      (cls),
    .r_out    (r_out),
    .g_out    (g_out),
    .b_out    (b_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a pixel until accepted; acc is the cycle index of the accepting edge.
  task automatic offer(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       output int acc);
    acc       = -1;
    pix_valid = 1'b1;
    r_in = r; g_in = g; b_in = b;
    for (int i = 0; i < 200; i++) begin
      if (pix_ready) begin
        tick();
        acc = cyc;
        break;
      end
      tick();
    end
    pix_valid = 1'b0;
    if (acc < 0) chk_eq("accept_timeout", 0, 1);
  endtask

  // Called right after the accept edge: LOAD edge (spikes driven, must be
  // ignored) then nk count edges with out_x high for the first n0/n1 of them.
  task automatic window(input int nk, input int n0, input int n1);
    w_rise = -1; w_bad = 0; w_st_run = -1; w_st_drain = -1;
    for (int k = -1; k < nk; k++) begin
      if (k < 0) begin
        out_0 = 1'b1; out_1 = 1'b1;
      end else begin
        out_0 = (k < n0); out_1 = (k < n1);
      end
      tick();
      if (res_ly_1 || res_ly_2 || !busy) w_bad++;
      if (k == 0)  w_st_run   = int'(r_st);
      if (k == 68) w_st_drain = int'(r_st);
      if (cls_valid && w_rise < 0) w_rise = cyc + 1;
    end
    out_0 = 1'b0; out_1 = 1'b0;
    if (nk == 69) begin
      for (int i = 0; i < 5 && w_rise < 0; i++) begin
        tick();
        if (cls_valid) w_rise = cyc + 1;
      end
      if (w_rise < 0) chk_eq("cls_valid_timeout", 0, 1);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; pix_valid = 1'b0;
    r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
    out_0 = 1'b0; out_1 = 1'b0; cls_ready = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("rst_res_ly_1", 32'(res_ly_1), 1);
      chk_eq("rst_res_ly_2", 32'(res_ly_2), 1);
      chk_eq("rst_pix_ready", 32'(pix_ready), 0);
      chk_eq("rst_busy", 32'(busy), 0);
    end
    chk_eq("rst_cls_valid", 32'(cls_valid), 0);
    chk_eq("rst_cls", 32'(cls), 0);
    chk_eq("rst_colour", {8'd0, r_out, g_out, b_out}, 0);
    chk_eq("rst_stim", {8'd0, r_st, g_st, b_st}, 0);
    reset = 1'b0;
    #1;
    chk_eq("rel_pix_ready", 32'(pix_ready), 1);
    chk_eq("rel_busy", 32'(busy), 0);
    tick();
    chk_eq("rel_res_ly", 32'(res_ly_1), 0);

    // Class 0 pixel: 30 spikes on out_0, 10 on out_1.
    cls_ready = 1'b1;
    offer(8'd200, 8'd10, 8'd10, acc_a);
    window(69, 30, 10);
    chk_eq("p1_latency", 32'(w_rise - acc_a), 71);
    chk_eq("p1_cls", 32'(cls), 1);
    chk_eq("p1_colour", {8'd0, r_out, g_out, b_out}, 32'h0000FF);
    chk_eq("p1_cnt0", 32'(dut.u_cnt0.count_q), 30);
    chk_eq("p1_cnt1", 32'(dut.u_cnt1.count_q), 10);
    chk_eq("p1_res_ly_in_window", 32'(w_bad), 0);
    chk_eq("p1_stim_run", 32'(w_st_run), 200);
    chk_eq("p1_stim_drain", 32'(w_st_drain), 0);
    tick();
    chk_eq("p1_idle_busy", 32'(busy), 0);
    chk_eq("p1_idle_valid", 32'(cls_valid), 0);

    // Both neurons qualify; neuron 0 wins and its count reaches 69.
    offer(8'd5, 8'd6, 8'd7, acc_a);
    window(69, 69, 26);
    chk_eq("p2_cls", 32'(cls), 1);
    chk_eq("p2_cnt0", 32'(dut.u_cnt0.count_q), 69);
    chk_eq("p2_cnt1", 32'(dut.u_cnt1.count_q), 26);
    tick();

    // Exactly threshold on out_1 with back-pressure on the result.
    cls_ready = 1'b0;
    offer(8'd9, 8'd9, 8'd9, acc_a);
    window(69, 0, 25);
    chk_eq("p3_cls", 32'(cls), 2);
    chk_eq("p3_colour", {8'd0, r_out, g_out, b_out}, 32'hFFFF00);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!cls_valid || cls != 2'd2 || {r_out, g_out, b_out} != 24'hFFFF00) unstable++;
    end
    chk_eq("p3_hold_stable", 32'(unstable), 0);
    cls_ready = 1'b1;
    tick();
    chk_eq("p3_idle_busy", 32'(busy), 0);
    chk_eq("p3_idle_valid", 32'(cls_valid), 0);

    // One below threshold on both neurons: no class.
    offer(8'd1, 8'd2, 8'd3, acc_a);
    window(69, 24, 24);
    chk_eq("p4_cls", 32'(cls), 0);
    chk_eq("p4_colour", {8'd0, r_out, g_out, b_out}, 0);
    tick();

    // Flush at RUN step 20 with a same-cycle pixel offer.
    offer(8'd50, 8'd60, 8'd70, acc_a);
    window(20, 20, 0);
    flush = 1'b1; pix_valid = 1'b1;
    r_in = 8'd1; g_in = 8'd2; b_in = 8'd3;
    #1;
    chk_eq("fl_pix_ready", 32'(pix_ready), 0);
    tick();
    flush = 1'b0;
    chk_eq("fl_res_ly_1", 32'(res_ly_1), 1);
    chk_eq("fl_res_ly_2", 32'(res_ly_2), 1);
    chk_eq("fl_busy", 32'(busy), 0);
    chk_eq("fl_cnt0_clr", 32'(dut.u_cnt0.count_q), 0);
    chk_eq("fl_stim_not_taken", 32'(r_st), 0);
    #1;
    chk_eq("fl_pix_ready_after", 32'(pix_ready), 1);
    tick();
    pix_valid = 1'b0;
    chk_eq("fl_accept_busy", 32'(busy), 1);
    chk_eq("fl_accept_stim", {8'd0, r_st, g_st, b_st}, 32'h010203);
    window(69, 0, 0);
    chk_eq("fl_cls", 32'(cls), 0);
    tick();

    // Back-to-back pixels with cls_ready high.
    offer(8'd200, 8'd10, 8'd10, acc_a);
    window(69, 30, 0);
    chk_eq("bb_a_cls", 32'(cls), 1);
    offer(8'd11, 8'd12, 8'd13, acc_b);
    chk_eq("bb_spacing", 32'(acc_b - acc_a), 72);
    window(69, 0, 0);
    chk_eq("bb_b_cls", 32'(cls), 0);
    chk_eq("bb_b_cnt0", 32'(dut.u_cnt0.count_q), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_pixel_sequencer.md
# snn_pixel_sequencer

Sequences one pixel at a time through the rate-coded SNN datapath: the spike encoder, the hidden layer and the output layer. It accepts an RGB pixel over a valid/ready handshake, latches it as encoder stimulus and pulses both layer resets. It then runs a fixed spike window while counting output-neuron spikes, and returns a class/colour result over a second valid/ready handshake. It replaces free-running per-pixel stepping with an explicit, back-pressurable scheduler between the video front end and the SNN core.

## Interface
Parameters:
- SP_STEPS, 64: encoder time steps per pixel (stimulus-active cycles).
- LAYER_DELAY, 5: drain cycles after stimulus so output-layer spikes still in flight are counted.
- N_SP_TO_ACTIVATE, 25: spike count at which an output neuron is considered active.
- CNT_W, 8: spike counter width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort, driven by the frame-start pulse.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  sequencer can accept a pixel.
- r_in, g_in, b_in  in  8 each  pixel components.
- r_st, g_st, b_st  out  8 each  stimulus values to the encoder.
- res_ly_1  out  1  hidden-layer membrane reset.
- res_ly_2  out  1  output-layer membrane reset.
- out_0, out_1  in  1 each  output-neuron spikes.
- cls_valid  out  1  result available.
- cls_ready  in  1  result consumed.
- cls  out  2  result class: 0 = none, 1 = class 0, 2 = class 1.
- r_out, g_out, b_out  out  8 each  result colour.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, RESULT.
- IDLE:
  - pix_ready = 1 unless reset or flush is high.
  - On pix_valid & pix_ready: latch r/g/b into r_st/g_st/b_st, then go to LOAD.
- LOAD (1 cycle):
  - res_ly_1 = res_ly_2 = 1.
  - Clear both spike counters.
  - Clear the step counter, then go to RUN.
- RUN (SP_STEPS cycles):
  - Stimulus held on r_st/g_st/b_st.
  - Step counter increments each cycle; on step == SP_STEPS-1, go to DRAIN.
- DRAIN (LAYER_DELAY cycles):
  - r_st/g_st/b_st forced to 0, so no new input spikes.
  - Go to RESULT on the last drain cycle.
- Counting:
  - In every RUN and DRAIN cycle, each counter increments when its out_x is high.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Spikes seen in IDLE, LOAD or RESULT are ignored.
- RESULT:
  - cls, r_out, g_out and b_out are registered on entry.
  - If cnt0 >= N_SP_TO_ACTIVATE: cls = 1, colour {0,0,255}.
  - Otherwise, if cnt1 >= N_SP_TO_ACTIVATE: cls = 2, colour {255,255,0}.
  - Otherwise: cls = 0, colour {0,0,0}.
  - cnt0 has priority when both counts qualify.
  - cls_valid = 1 and holds, with cls and colour stable, until cls_valid & cls_ready; then go to IDLE.
- flush (any state):
  - Next state is IDLE; counters cleared; cls_valid drops the next cycle.
  - res_ly_1 and res_ly_2 pulse for 1 cycle.
  - flush wins over a same-cycle pix_valid, and that pixel is not accepted.
  - flush wins over a same-cycle cls_ready; the result is discarded.
- Reset, including mid-operation:
  - State goes to IDLE; counters and step counter go to 0.
  - r_st/g_st/b_st = 0, cls_valid = 0, cls = 0, colour = 0.
  - res_ly_1 = res_ly_2 = 1 while reset is high; pix_ready = 0 and busy = 0 while reset is high.

## Timing
- Pixel accepted at edge T:
  - LOAD at T+1.
  - RUN from T+2 to T+1+SP_STEPS.
  - DRAIN for the next LAYER_DELAY cycles.
  - cls_valid first high at T+2+SP_STEPS+LAYER_DELAY (T+71 with defaults).
- Back-to-back throughput with cls_ready tied high: one pixel every SP_STEPS+LAYER_DELAY+3 cycles (72 with defaults).
- pix_ready is combinational from state, reset and flush. All other outputs are registered.
- res_ly_1 and res_ly_2 are never high during RUN or DRAIN, except on flush or reset.
- The step counter is $clog2(SP_STEPS) bits wide. The drain counter is $clog2(LAYER_DELAY+1) bits wide.

## Structure
- Shared package snn_pkg holds:
  - the state enum;
  - class codes CLS_NONE / CLS_0 / CLS_1;
  - colour constants BLUE, YELLOW, BLACK.
- Sub-module snn_spike_counter: a CNT_W-bit saturating counter with clear and enable, instantiated twice.

## Test plan
- Reset held 3 cycles, then released: res_ly_1/2 high during reset, and all outputs at their reset values. pix_ready = 1 on the first cycle after release, and busy = 0.
- Pixel (200,10,10) accepted at T with out_0 driven high for 30 RUN cycles and out_1 for 10: cls_valid rises at T+71 with cls = 1 and colour 0,0,255.
- out_0 held high for all 69 count cycles and out_1 for 26: cls = 1, cnt0 = 69 (no wrap), because cnt0 has priority.
- out_1 spikes 25 times with out_0 low, and cls_ready held low for 10 cycles: cls = 2, colour 255,255,0 held stable until the cls_ready handshake; IDLE on the next cycle.
- flush asserted at step 20 of RUN, with pix_valid high in the same cycle: IDLE on the next cycle and res_ly pulses once. The pixel is not accepted on that cycle but is accepted on the following one.
- Two pixels back-to-back with cls_ready = 1: accepts occur exactly 72 cycles apart, with no spike counts carried over between pixels.
